char_phys_ctrl: RTL and testbench
=================================

# char_phys_ctrl

Parametrised character controller for player and NPC instances. Generalises the fixed-step movement block into a frame-ticked physics engine: horizontal speed, gravity-based jump arc, screen clamping, an HP/damage/heal model with invulnerability frames, and a timed weapon-attack FSM. It sits between the input decoders (keyboard/mouse) and the sprite/weapon draw stages, which consume its position, facing and attack outputs.

## Interface
- SCREEN_W, 1024: playfield width in pixels.
- CHAR_W, 32: sprite width in pixels.
- CHAR_H, 48: sprite height in pixels.
- GROUND_Y, 700: floor line y; grounded character has pos_y = GROUND_Y - CHAR_H.
- START_X, 100: reset x position.
- STEP_X, 4: pixels moved per frame horizontally.
- JUMP_V, 14: initial upward speed in px/frame.
- GRAVITY, 1: speed increment per frame.
- MAX_FALL, 16: terminal downward speed.
- MAX_HP, 10: full health (≤15).
- INVULN_FRAMES, 60: frames of damage immunity after a hit.
- ATK_FRAMES, 12: frames draw_weapon is high per attack.
- ATK_COOLDOWN, 20: frames after an attack before another can start.

- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (start of vblank); all state advances only on this cycle.
- stepleft  in  1  move-left request (level).
- stepright  in  1  move-right request (level).
- stepjump  in  1  jump request (level).
- mouse_left  in  1  attack request (level).
- on_ground  in  1  platform contact from collision logic (level).
- dmg_valid  in  1  one-cycle damage pulse, any cycle.
- dmg_amt  in  4  damage amount, sampled with dmg_valid.
- heal_valid  in  1  one-cycle +1 HP pulse, any cycle.
- pos_x  out  12  sprite left x.
- pos_y  out  12  sprite top y.
- char_hp  out  4  current HP.
- flip_h  out  1  1 = facing left.
- draw_weapon  out  1  attack active.
- ground_lvl  out  1  1 = grounded.
- invuln  out  1  immunity window active.
- alive  out  1  0 once HP reaches 0.

## Operation
- Reset: pos_x=START_X, pos_y=GROUND_Y-CHAR_H, vel_y=0, char_hp=MAX_HP, flip_h=0, draw_weapon=0, ground_lvl=1, invuln=0, alive=1, attack FSM READY, pending dmg/heal cleared.
- Motion FSM: GROUNDED, AIRBORNE, DEAD.
  - GROUNDED: stepjump on tick → vel_y=-JUMP_V, AIRBORNE, ground_lvl=0. Without floor support (on_ground=0 and pos_y below floor-line not reached) → AIRBORNE with vel_y=0.
  - AIRBORNE: per tick pos_y+=vel_y, then vel_y=min(vel_y+GRAVITY, MAX_FALL). Landing when vel_y≥0 and (pos_y+vel_y ≥ GROUND_Y-CHAR_H or on_ground=1): pos_y snaps to GROUND_Y-CHAR_H (floor case) or holds (platform case), vel_y=0, GROUNDED. Upward move clamped at y=0 with vel_y forced to 0.
  - DEAD: entered when HP hits 0; position frozen, all requests ignored, draw_weapon=0; exits only on rst.
- Horizontal (GROUNDED/AIRBORNE): stepleft only → pos_x=max(pos_x-STEP_X,0), flip_h=1; stepright only → pos_x=min(pos_x+STEP_X, SCREEN_W-CHAR_W), flip_h=0; both or neither → no move, flip_h held.
- vel_y is signed 8-bit; position arithmetic done in 13-bit signed, then clamped before writing 12-bit outputs.
- HP: dmg_valid/heal_valid latch into pending registers (multiple pulses in one frame: largest dmg_amt kept, heal OR'd). Applied on tick: if damage pending and invuln=0 → hp=sat(hp-dmg_amt,0), start invuln counter=INVULN_FRAMES; damage during invuln discarded. Heal applied only if no damage applied that tick, saturates at MAX_HP. dmg_amt=0 counts as a hit (starts invuln).
- Attack FSM READY → ACTIVE (mouse_left on tick, draw_weapon=1, ATK_FRAMES) → COOLDOWN (ATK_COOLDOWN) → READY. Held mouse_left re-triggers only after COOLDOWN.

## Timing
- All outputs registered; change one clk after the frame_tick cycle, otherwise stable for the whole frame.
- dmg/heal pulse in the same cycle as frame_tick is applied on that tick.
- invuln deasserts on the tick its counter reaches 0; exactly INVULN_FRAMES ticks immune.
- Reset mid-jump or mid-attack returns every output to reset values on next clk.

## Test plan
- Reset, hold stepright 300 ticks → pos_x saturates at 992, flip_h=0; then both steps 5 ticks → pos_x stays 992.
- Pulse stepjump on one tick → pos_y 652 then 638, apex after 14 ticks, lands back at 652 with ground_lvl=1 after 29 ticks total.
- dmg_amt=3 pulse → hp 7, invuln=1; second dmg within 60 ticks → hp stays 7; after 60 ticks dmg_amt=9 → hp 0, alive=0, inputs ignored.
- heal_valid at hp=10 → stays 10; dmg_amt=2 and heal_valid same frame → hp 8.
- Hold mouse_left 100 ticks → draw_weapon high 12 ticks, low 20, repeats (period 32).
- rst asserted mid-air during attack → pos_y=652, draw_weapon=0, hp=10 next clk.

Source files
------------

// File: rtl/char_phys_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : char_phys_ctrl_if
//  Description : Bundle between the input decoders / draw stages and the
//                character controller. Names are seen from the controller
//                side: i_* flow into it, o_* flow out of it.
//                  i_frame_tick  one-cycle pulse per frame
//                  i_stepleft / i_stepright / i_stepjump  movement requests
//                  i_mouse_left  attack request
//                  i_on_ground   platform contact
//                  i_dmg_valid / i_dmg_amt  damage pulse and amount
//                  i_heal_valid  +1 HP pulse
//                  o_pos_x / o_pos_y  sprite top-left
//                  o_char_hp, o_flip_h, o_draw_weapon, o_ground_lvl,
//                  o_invuln, o_alive  status
//  Revision    : 1.0 - initial release
// ============================================================================
interface char_phys_ctrl_if;
  logic        i_frame_tick;
  logic        i_stepleft;
  logic        i_stepright;
  logic        i_stepjump;
  logic        i_mouse_left;
  logic        i_on_ground;
  logic        i_dmg_valid;
  logic [3:0]  i_dmg_amt;
  logic        i_heal_valid;
  logic [11:0] o_pos_x;
  logic [11:0] o_pos_y;
  logic [3:0]  o_char_hp;
  logic        o_flip_h;
  logic        o_draw_weapon;
  logic        o_ground_lvl;
  logic        o_invuln;
  logic        o_alive;

  // Controller side
  modport slave (
    input  i_frame_tick, i_stepleft, i_stepright, i_stepjump, i_mouse_left,
           i_on_ground, i_dmg_valid, i_dmg_amt, i_heal_valid,
    output o_pos_x, o_pos_y, o_char_hp, o_flip_h, o_draw_weapon,
           o_ground_lvl, o_invuln, o_alive
  );

  // Driver side (decoders / draw stages / testbench)
  modport master (
    output i_frame_tick, i_stepleft, i_stepright, i_stepjump, i_mouse_left,
           i_on_ground, i_dmg_valid, i_dmg_amt, i_heal_valid,
    input  o_pos_x, o_pos_y, o_char_hp, o_flip_h, o_draw_weapon,
           o_ground_lvl, o_invuln, o_alive
  );
endinterface
`default_nettype wire

// File: rtl/char_phys_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : char_phys_ctrl
//  Description : Frame-ticked character controller: horizontal stepping with
//                screen clamp, gravity jump arc with floor/platform landing,
//                HP with damage/heal and invulnerability frames, and a timed
//                weapon attack FSM. State advances only on i_frame_tick;
//                damage/heal pulses may arrive on any cycle and are held
//                until the next tick.
//  Ports       : clk  - pixel clock
//                rst  - synchronous active-high reset
//                bus  - char_phys_ctrl_if.slave (requests in, status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module char_phys_ctrl #(
  parameter int SCREEN_W      = 1024,
  parameter int CHAR_W        = 32,
  parameter int CHAR_H        = 48,
  parameter int GROUND_Y      = 700,
  parameter int START_X       = 100,
  parameter int STEP_X        = 4,
  parameter int JUMP_V        = 14,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 16,
  parameter int MAX_HP        = 10,
  parameter int INVULN_FRAMES = 60,
  parameter int ATK_FRAMES    = 12,
  parameter int ATK_COOLDOWN  = 20
) (
  input  wire logic       clk,
  input  wire logic       rst,
  char_phys_ctrl_if.slave bus
);

  localparam logic signed [12:0] c_STEP_X   = 13'(STEP_X);
  localparam logic signed [12:0] c_X_MAX    = 13'(SCREEN_W - CHAR_W);
  localparam logic signed [12:0] c_FLOOR_Y  = 13'(GROUND_Y - CHAR_H);
  localparam logic        [11:0] c_START_X  = 12'(START_X);
  localparam logic        [11:0] c_FLOOR_12 = 12'(GROUND_Y - CHAR_H);
  localparam logic signed [7:0]  c_JUMP_VEL = 8'(-JUMP_V);
  localparam logic signed [7:0]  c_GRAV     = 8'(GRAVITY);
  localparam logic signed [7:0]  c_MAX_FALL = 8'(MAX_FALL);
  localparam logic        [3:0]  c_MAX_HP   = 4'(MAX_HP);
  localparam logic        [7:0]  c_INV_INIT = 8'(INVULN_FRAMES);
  localparam logic        [7:0]  c_ATK_LAST = 8'(ATK_FRAMES - 1);
  localparam logic        [7:0]  c_CD_LAST  = 8'(ATK_COOLDOWN - 1);

  // Motion FSM
  localparam logic [1:0] c_MV_GROUNDED = 2'd0;
  localparam logic [1:0] c_MV_AIRBORNE = 2'd1;
  localparam logic [1:0] c_MV_DEAD     = 2'd2;

  // Attack FSM
  localparam logic [1:0] c_AT_READY    = 2'd0;
  localparam logic [1:0] c_AT_ACTIVE   = 2'd1;
  localparam logic [1:0] c_AT_COOLDOWN = 2'd2;

  logic [11:0]       r_pos_x, r_pos_y;
  logic signed [7:0] r_vel_y;
  logic [1:0]        r_mv_state;
  logic              r_flip;
  logic [3:0]        r_hp;
  logic [7:0]        r_inv_cnt;
  logic [1:0]        r_at_state;
  logic [7:0]        r_at_cnt;
  logic              r_dmg_pend;
  logic [3:0]        r_dmg_amt;
  logic              r_heal_pend;
  logic              r_draw, r_ground, r_invuln, r_alive;

  logic [11:0]        w_pos_x_nx, w_pos_y_nx;
  logic signed [7:0]  w_vel_nx, w_vel_grav;
  logic [1:0]         w_mv_nx, w_at_nx;
  logic               w_flip_nx;
  logic [3:0]         w_hp_nx, w_dmg_max, w_hp_sat;
  logic [7:0]         w_inv_nx, w_atc_nx;
  logic               w_dmg_any, w_heal_any, w_dies, w_tick, w_live;
  logic signed [12:0] w_x_dec, w_x_inc, w_y_sum;

  assign w_tick = bus.i_frame_tick;
  assign w_live = (r_mv_state != c_MV_DEAD);

  // Pulses arriving on the tick cycle itself join whatever is pending.
  assign w_dmg_any  = r_dmg_pend | bus.i_dmg_valid;
  assign w_heal_any = r_heal_pend | bus.i_heal_valid;
  always_comb begin
    w_dmg_max = r_dmg_amt;
    if (bus.i_dmg_valid) begin
      if (!r_dmg_pend || (bus.i_dmg_amt > r_dmg_amt)) w_dmg_max = bus.i_dmg_amt;
    end
  end
  assign w_hp_sat = (r_hp > w_dmg_max) ? (r_hp - w_dmg_max) : 4'd0;

  // HP / invulnerability
  always_comb begin
    w_hp_nx  = r_hp;
    w_inv_nx = r_inv_cnt;
    w_dies   = 1'b0;
    if (w_tick && w_live) begin
      if (w_dmg_any && (r_inv_cnt == 8'd0)) begin
        w_hp_nx  = w_hp_sat;
        w_inv_nx = c_INV_INIT;
        w_dies   = (w_hp_sat == 4'd0);
      end else begin
        if (r_inv_cnt != 8'd0) w_inv_nx = r_inv_cnt - 8'd1;
        if (w_heal_any && (r_hp < c_MAX_HP)) w_hp_nx = r_hp + 4'd1;
      end
    end
  end

  // Position arithmetic in 13-bit signed so under/overflow is visible
  // before clamping into the 12-bit outputs.
  assign w_x_dec = $signed({1'b0, r_pos_x}) - c_STEP_X;
  assign w_x_inc = $signed({1'b0, r_pos_x}) + c_STEP_X;
  assign w_y_sum = $signed({1'b0, r_pos_y}) + $signed({{5{r_vel_y[7]}}, r_vel_y});

  always_comb begin
    w_vel_grav = r_vel_y + c_GRAV;
    if (w_vel_grav > c_MAX_FALL) w_vel_grav = c_MAX_FALL;
  end

  // Motion
  always_comb begin
    w_pos_x_nx = r_pos_x;
    w_pos_y_nx = r_pos_y;
    w_vel_nx   = r_vel_y;
    w_mv_nx    = r_mv_state;
    w_flip_nx  = r_flip;
    if (w_tick && w_live) begin
      if (w_dies) begin
        // Position freezes on the killing tick itself.
        w_mv_nx = c_MV_DEAD;
      end else begin
        if (bus.i_stepleft && !bus.i_stepright) begin
          w_pos_x_nx = (w_x_dec < 13'sd0) ? 12'd0 : w_x_dec[11:0];
          w_flip_nx  = 1'b1;
        end else if (bus.i_stepright && !bus.i_stepleft) begin
          w_pos_x_nx = (w_x_inc > c_X_MAX) ? c_X_MAX[11:0] : w_x_inc[11:0];
          w_flip_nx  = 1'b0;
        end

        case (r_mv_state)
          c_MV_GROUNDED: begin
            if (bus.i_stepjump) begin
              w_vel_nx = c_JUMP_VEL;
              w_mv_nx  = c_MV_AIRBORNE;
            end else if (!bus.i_on_ground && ($signed({1'b0, r_pos_y}) < c_FLOOR_Y)) begin
              // Walked off a platform: start falling from rest.
              w_vel_nx = 8'sd0;
              w_mv_nx  = c_MV_AIRBORNE;
            end
          end
          c_MV_AIRBORNE: begin
            if (!r_vel_y[7] && (w_y_sum >= c_FLOOR_Y)) begin
              w_pos_y_nx = c_FLOOR_12;
              w_vel_nx   = 8'sd0;
              w_mv_nx    = c_MV_GROUNDED;
            end else if (!r_vel_y[7] && bus.i_on_ground) begin
              w_vel_nx = 8'sd0;
              w_mv_nx  = c_MV_GROUNDED;
            end else if (w_y_sum < 13'sd0) begin
              // Head hit the top of the screen: kill upward speed.
              w_pos_y_nx = 12'd0;
              w_vel_nx   = 8'sd0;
            end else begin
              w_pos_y_nx = w_y_sum[11:0];
              w_vel_nx   = w_vel_grav;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Attack. A held button re-fires straight out of cooldown so the
  // weapon period is exactly ATK_FRAMES + ATK_COOLDOWN.
  always_comb begin
    w_at_nx  = r_at_state;
    w_atc_nx = r_at_cnt;
    if (w_tick) begin
      if (!w_live || w_dies) begin
        w_at_nx  = c_AT_READY;
        w_atc_nx = 8'd0;
      end else begin
        case (r_at_state)
          c_AT_READY: begin
            if (bus.i_mouse_left) begin
              w_at_nx  = c_AT_ACTIVE;
              w_atc_nx = c_ATK_LAST;
            end
          end
          c_AT_ACTIVE: begin
            if (r_at_cnt == 8'd0) begin
              w_at_nx  = c_AT_COOLDOWN;
              w_atc_nx = c_CD_LAST;
            end else begin
              w_atc_nx = r_at_cnt - 8'd1;
            end
          end
          c_AT_COOLDOWN: begin
            if (r_at_cnt != 8'd0) begin
              w_atc_nx = r_at_cnt - 8'd1;
            end else if (bus.i_mouse_left) begin
              w_at_nx  = c_AT_ACTIVE;
              w_atc_nx = c_ATK_LAST;
            end else begin
              w_at_nx  = c_AT_READY;
            end
          end
          default: begin
            w_at_nx  = c_AT_READY;
            w_atc_nx = 8'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos_x     <= c_START_X;
      r_pos_y     <= c_FLOOR_12;
      r_vel_y     <= 8'sd0;
      r_mv_state  <= c_MV_GROUNDED;
      r_flip      <= 1'b0;
      r_hp        <= c_MAX_HP;
      r_inv_cnt   <= 8'd0;
      r_at_state  <= c_AT_READY;
      r_at_cnt    <= 8'd0;
      r_dmg_pend  <= 1'b0;
      r_dmg_amt   <= 4'd0;
      r_heal_pend <= 1'b0;
      r_draw      <= 1'b0;
      r_ground    <= 1'b1;
      r_invuln    <= 1'b0;
      r_alive     <= 1'b1;
    end else begin
      r_pos_x    <= w_pos_x_nx;
      r_pos_y    <= w_pos_y_nx;
      r_vel_y    <= w_vel_nx;
      r_mv_state <= w_mv_nx;
      r_flip     <= w_flip_nx;
      r_hp       <= w_hp_nx;
      r_inv_cnt  <= w_inv_nx;
      r_at_state <= w_at_nx;
      r_at_cnt   <= w_atc_nx;
      r_draw     <= (w_at_nx == c_AT_ACTIVE);
      r_ground   <= (w_mv_nx == c_MV_GROUNDED);
      r_invuln   <= (w_inv_nx != 8'd0);
      r_alive    <= (w_mv_nx != c_MV_DEAD);
      if (w_tick) begin
        r_dmg_pend  <= 1'b0;
        r_dmg_amt   <= 4'd0;
        r_heal_pend <= 1'b0;
      end else begin
        r_dmg_pend  <= w_dmg_any;
        r_dmg_amt   <= w_dmg_max;
        r_heal_pend <= w_heal_any;
      end
    end
  end

  assign bus.o_pos_x       = r_pos_x;
  assign bus.o_pos_y       = r_pos_y;
  assign bus.o_char_hp     = r_hp;
  assign bus.o_flip_h      = r_flip;
  assign bus.o_draw_weapon = r_draw;
  assign bus.o_ground_lvl  = r_ground;
  assign bus.o_invuln      = r_invuln;
  assign bus.o_alive       = r_alive;

endmodule
`default_nettype wire

// File: tb/tb_char_phys_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_char_phys_ctrl
//  Description : Directed self-checking bench for char_phys_ctrl with
//                hand-computed expected values (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_char_phys_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  char_phys_ctrl_if bus();

  char_phys_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: tick for one cycle (optionally with dmg/heal in the same
  // cycle), then leave outputs settled for sampling.
  task automatic frame(input bit dmg = 1'b0, input logic [3:0] amt = 4'd0, input bit heal = 1'b0);
    @(negedge clk);
    bus.i_frame_tick = 1'b1;
    bus.i_dmg_valid  = dmg;
    bus.i_dmg_amt    = amt;
    bus.i_heal_valid = heal;
    @(negedge clk);
    bus.i_frame_tick = 1'b0;
    bus.i_dmg_valid  = 1'b0;
    bus.i_dmg_amt    = 4'd0;
    bus.i_heal_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Damage/heal pulse on a non-tick cycle.
  task automatic pulse(input bit dmg, input logic [3:0] amt, input bit heal);
    @(negedge clk);
    bus.i_dmg_valid  = dmg;
    bus.i_dmg_amt    = amt;
    bus.i_heal_valid = heal;
    @(negedge clk);
    bus.i_dmg_valid  = 1'b0;
    bus.i_dmg_amt    = 4'd0;
    bus.i_heal_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_frame_tick = 1'b0;
    bus.i_stepleft   = 1'b0;
    bus.i_stepright  = 1'b0;
    bus.i_stepjump   = 1'b0;
    bus.i_mouse_left = 1'b0;
    bus.i_on_ground  = 1'b0;
    bus.i_dmg_valid  = 1'b0;
    bus.i_dmg_amt    = 4'd0;
    bus.i_heal_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_pos_x", 32'(bus.o_pos_x), 100);
    check("rst_pos_y", 32'(bus.o_pos_y), 652);
    check("rst_hp", 32'(bus.o_char_hp), 10);
    check("rst_flip", 32'(bus.o_flip_h), 0);
    check("rst_draw", 32'(bus.o_draw_weapon), 0);
    check("rst_ground", 32'(bus.o_ground_lvl), 1);
    check("rst_invuln", 32'(bus.o_invuln), 0);
    check("rst_alive", 32'(bus.o_alive), 1);

    // Horizontal
    bus.i_stepleft = 1'b1;
    frame();
    check("left1_x", 32'(bus.o_pos_x), 96);
    check("left1_flip", 32'(bus.o_flip_h), 1);
    bus.i_stepleft  = 1'b0;
    bus.i_stepright = 1'b1;
    frames(300);
    check("right_sat_x", 32'(bus.o_pos_x), 992);
    check("right_flip", 32'(bus.o_flip_h), 0);
    bus.i_stepleft = 1'b1;
    frames(5);
    check("both_x", 32'(bus.o_pos_x), 992);
    check("both_flip", 32'(bus.o_flip_h), 0);
    bus.i_stepright = 1'b0;
    frames(260);
    check("left_sat_x", 32'(bus.o_pos_x), 0);
    check("left_flip", 32'(bus.o_flip_h), 1);
    bus.i_stepleft = 1'b0;
    frame();
    check("idle_flip_held", 32'(bus.o_flip_h), 1);

    // Jump arc to the floor
    bus.i_stepjump = 1'b1;
    frame();
    bus.i_stepjump = 1'b0;
    check("jump_tick_y", 32'(bus.o_pos_y), 652);
    check("jump_tick_gnd", 32'(bus.o_ground_lvl), 0);
    frame();
    check("jump_first_y", 32'(bus.o_pos_y), 638);
    frames(13);
    check("apex_y", 32'(bus.o_pos_y), 547);
    frames(14);
    check("fall_y", 32'(bus.o_pos_y), 638);
    check("fall_gnd", 32'(bus.o_ground_lvl), 0);
    frame();
    check("land_y", 32'(bus.o_pos_y), 652);
    check("land_gnd", 32'(bus.o_ground_lvl), 1);

    // Platform landing at the apex, then walk-off fall
    bus.i_stepjump = 1'b1;
    frame();
    bus.i_stepjump = 1'b0;
    frames(14);
    bus.i_on_ground = 1'b1;
    frame();
    check("plat_y", 32'(bus.o_pos_y), 547);
    check("plat_gnd", 32'(bus.o_ground_lvl), 1);
    bus.i_on_ground = 1'b0;
    frame();
    check("walkoff_y", 32'(bus.o_pos_y), 547);
    check("walkoff_gnd", 32'(bus.o_ground_lvl), 0);
    frames(15);
    check("walkoff_land_y", 32'(bus.o_pos_y), 652);
    check("walkoff_land_gnd", 32'(bus.o_ground_lvl), 1);

    // HP model
    pulse(1'b0, 4'd0, 1'b1);
    frame();
    check("heal_full_hp", 32'(bus.o_char_hp), 10);
    frame(1'b1, 4'd3, 1'b0);                 // hit on the tick cycle itself
    check("dmg3_hp", 32'(bus.o_char_hp), 7);
    check("dmg3_inv", 32'(bus.o_invuln), 1);
    frame();
    pulse(1'b1, 4'd5, 1'b0);
    frame();
    check("inv_block_hp", 32'(bus.o_char_hp), 7);
    frames(57);
    check("inv_59_still", 32'(bus.o_invuln), 1);
    frame();
    check("inv_60_clear", 32'(bus.o_invuln), 0);
    pulse(1'b0, 4'd0, 1'b1);
    frame();
    check("heal_hp", 32'(bus.o_char_hp), 8);
    pulse(1'b1, 4'd2, 1'b1);
    frame();
    check("dmg_heal_hp", 32'(bus.o_char_hp), 6);
    frames(60);
    pulse(1'b1, 4'd4, 1'b0);
    pulse(1'b1, 4'd1, 1'b0);
    frame();
    check("dmg_max_hp", 32'(bus.o_char_hp), 2);
    frames(60);
    bus.i_stepright  = 1'b1;
    bus.i_stepjump   = 1'b1;
    bus.i_mouse_left = 1'b1;
    frame(1'b1, 4'd9, 1'b0);
    check("dead_hp", 32'(bus.o_char_hp), 0);
    check("dead_alive", 32'(bus.o_alive), 0);
    pulse(1'b0, 4'd0, 1'b1);
    frames(5);
    check("dead_hp_held", 32'(bus.o_char_hp), 0);
    check("dead_x", 32'(bus.o_pos_x), 0);
    check("dead_y", 32'(bus.o_pos_y), 652);
    check("dead_draw", 32'(bus.o_draw_weapon), 0);
    bus.i_stepright  = 1'b0;
    bus.i_stepjump   = 1'b0;
    bus.i_mouse_left = 1'b0;
    do_reset();
    check("revive_alive", 32'(bus.o_alive), 1);

    // Attack cadence with the button held
    bus.i_mouse_left = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      frame();
      check("atk_draw", 32'(bus.o_draw_weapon), (((k - 1) % 32) < 12) ? 1 : 0);
    end
    bus.i_mouse_left = 1'b0;

    // Reset mid-air during an attack
    do_reset();
    bus.i_stepjump   = 1'b1;
    bus.i_mouse_left = 1'b1;
    frame();
    bus.i_stepjump   = 1'b0;
    bus.i_mouse_left = 1'b0;
    frames(2);
    frame(1'b1, 4'd4, 1'b0);
    check("air_y", 32'(bus.o_pos_y), 613);
    check("air_draw", 32'(bus.o_draw_weapon), 1);
    check("air_hp", 32'(bus.o_char_hp), 6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_y", 32'(bus.o_pos_y), 652);
    check("mid_rst_draw", 32'(bus.o_draw_weapon), 0);
    check("mid_rst_hp", 32'(bus.o_char_hp), 10);
    check("mid_rst_gnd", 32'(bus.o_ground_lvl), 1);
    check("mid_rst_inv", 32'(bus.o_invuln), 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
